// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/UART handshake bundle; stats signals exist only with UART_TX_ARB_STATS_EN
interface uart_tx_arbiter_if;
  logic [7:0] a_data;
  logic       a_wr;
  logic       a_last;
  logic       a_busy;
  logic [7:0] b_data;
  logic       b_wr;
  logic       b_last;
  logic       b_busy;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout;
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
  logic [7:0]  cnt_to;
  logic        stats_clr;
`endif
  modport master (
    output a_data, a_wr, a_last, b_data, b_wr, b_last, tx_busy,
    input  a_busy, b_busy, tx_data, tx_wr, grant, timeout
`ifdef UART_TX_ARB_STATS_EN
    , output stats_clr, input cnt_a, cnt_b, cnt_to
`endif
  );
  modport slave (
    input  a_data, a_wr, a_last, b_data, b_wr, b_last, tx_busy,
    output a_busy, b_busy, tx_data, tx_wr, grant, timeout
`ifdef UART_TX_ARB_STATS_EN
    , input stats_clr, output cnt_a, cnt_b, cnt_to
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin sharing of one UART tx between sources A/B; optional counters via UART_TX_ARB_STATS_EN
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int TO_W = 16
) (
  input logic clk,
  input logic reset_n,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, OWN, ISSUE, SETTLE, DRAIN} state_t;
  state_t state;
  logic a_full, b_full, a_hl, b_hl, ptr, last_q;
  logic [7:0] a_hd, b_hd;
  logic [TO_W-1:0] cnt;
  logic a_acc, b_acc, own_full, own_acc, own_last;
  logic [7:0] own_data;
  assign a_acc = bus.a_wr & ~a_full;
  assign b_acc = bus.b_wr & ~b_full;
  assign bus.a_busy = a_full;
  assign bus.b_busy = b_full;
  assign own_full = bus.grant[1] ? b_full : a_full;
  assign own_acc = bus.grant[1] ? b_acc : a_acc;
  assign own_last = bus.grant[1] ? b_hl : a_hl;
  assign own_data = bus.grant[1] ? b_hd : a_hd;
  // holding registers: capture when empty, release in the cycle the byte is issued
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_hd <= '0;
      b_hd <= '0;
      a_hl <= 1'b0;
      b_hl <= 1'b0;
    end else begin
      if (a_acc) begin
        a_full <= 1'b1;
        a_hd <= bus.a_data;
        a_hl <= bus.a_last;
      end else if (state == ISSUE && bus.grant[0]) a_full <= 1'b0;
      if (b_acc) begin
        b_full <= 1'b1;
        b_hd <= bus.b_data;
        b_hl <= bus.b_last;
      end else if (state == ISSUE && bus.grant[1]) b_full <= 1'b0;
    end
  // ownership FSM; counter defaults to clear so every state change resets it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      cnt <= '0;
      last_q <= 1'b0;
      bus.tx_wr <= 1'b0;
      bus.tx_data <= '0;
      bus.grant <= '0;
      bus.timeout <= 1'b0;
    end else begin
      bus.tx_wr <= 1'b0;
      bus.timeout <= 1'b0;
      cnt <= '0;
      case (state)
        IDLE:
          if (a_full | b_full) begin
            bus.grant <= (a_full & (~b_full | ~ptr)) ? 2'b01 : 2'b10;
            if (a_full & b_full) ptr <= ~ptr;
            state <= OWN;
          end
        OWN:
          if (own_full & ~bus.tx_busy) begin
            bus.tx_wr <= 1'b1;
            bus.tx_data <= own_data;
            state <= ISSUE;
          end else if (own_full) cnt <= cnt;
          else if (cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            bus.timeout <= 1'b1;
            bus.grant <= '0;
            state <= IDLE;
          end else cnt <= own_acc ? '0 : cnt + 1'b1;
        ISSUE: begin
          last_q <= own_last;
          state <= SETTLE;
        end
        SETTLE: state <= DRAIN;
        DRAIN:
          if (!bus.tx_busy) begin
            if (last_q) bus.grant <= '0;
            state <= last_q ? IDLE : OWN;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] ca, cb;
  logic [7:0] ct;
  assign bus.cnt_a = ca;
  assign bus.cnt_b = cb;
  assign bus.cnt_to = ct;
  // saturating issue/release counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || bus.stats_clr) begin
      ca <= '0;
      cb <= '0;
      ct <= '0;
    end else begin
      if (bus.tx_wr & bus.grant[0] & ~&ca) ca <= ca + 1'b1;
      if (bus.tx_wr & bus.grant[1] & ~&cb) cb <= cb + 1'b1;
      if (bus.timeout & ~&ct) ct <= ct + 1'b1;
    end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus hand sequences for lock, timeout and reset corners
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.LOCK_TIMEOUT(8), .TO_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic aw; logic [7:0] ad; logic al;
    logic bw; logic [7:0] bd; logic bl;
    logic busy;
    logic [13:0] exp;
  } vec_t;
  vec_t vq[$];
  int tests = 0, fails = 0;
  logic use_model = 1'b0, vec_busy = 1'b0;
  logic [1:0] bcnt;
  logic [7:0] log_q[$];
  // simple UART: busy for three cycles starting the cycle after tx_wr
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bcnt <= 2'd0;
    else if (bus.tx_wr) bcnt <= 2'd3;
    else if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
  assign bus.tx_busy = use_model ? (bcnt != 2'd0) : vec_busy;
  always @(posedge clk) if (bus.tx_wr) log_q.push_back(bus.tx_data);
  function automatic logic [13:0] outs();
    return {bus.tx_wr, bus.tx_data, bus.grant, bus.timeout, bus.a_busy, bus.b_busy};
  endfunction
  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic add(input logic aw, input logic [7:0] ad, input logic al, input logic bw, input logic [7:0] bd,
                     input logic bl, input logic busy, input logic ew, input logic [7:0] ed, input logic [1:0] eg,
                     input logic et, input logic eab, input logic ebb);
    vec_t v;
    v.aw = aw; v.ad = ad; v.al = al; v.bw = bw; v.bd = bd; v.bl = bl; v.busy = busy;
    v.exp = {ew, ed, eg, et, eab, ebb};
    vq.push_back(v);
  endtask
  task automatic send(input logic src, input logic [7:0] d, input logic l);
    for (int i = 0; i < 100 && (src ? bus.b_busy : bus.a_busy); i++) begin
      @(posedge clk);
      #1;
    end
    check(src ? "send_b_ready" : "send_a_ready", 40'(src ? bus.b_busy : bus.a_busy), 40'd0);
    if (src) begin bus.b_data = d; bus.b_last = l; bus.b_wr = 1'b1; end
    else begin bus.a_data = d; bus.a_last = l; bus.a_wr = 1'b1; end
    @(posedge clk);
    #1;
    bus.a_wr = 1'b0;
    bus.b_wr = 1'b0;
  endtask
  task automatic wait_log(input int n, input string name);
    for (int i = 0; i < 300 && log_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 40'(log_q.size()), 40'(n));
  endtask
  task automatic wait_gnt0(input string name);
    for (int i = 0; i < 100 && bus.grant != 2'b00; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 40'(bus.grant), 40'd0);
  endtask
  task automatic wait_tx_wr(input string name);
    for (int i = 0; i < 50 && !bus.tx_wr; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 40'(bus.tx_wr), 40'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    bus.a_wr = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
    bus.b_wr = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
`ifdef UART_TX_ARB_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset", 40'(outs()), 40'd0);
    reset_n = 1'b1;
    // single A byte, then simultaneous A/B with A continuing its frame
    add(1, 8'h67, 1, 0, 8'h00, 0, 0,  0, 8'h00, 2'b00, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h00, 2'b01, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 8'h67, 2'b01, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h67, 2'b01, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h67, 2'b01, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h67, 2'b01, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h67, 2'b00, 0, 0, 0);
    add(1, 8'h41, 0, 1, 8'h42, 1, 0,  0, 8'h67, 2'b00, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h67, 2'b01, 0, 1, 1);
    add(1, 8'h99, 1, 0, 8'h00, 0, 0,  1, 8'h41, 2'b01, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h41, 2'b01, 0, 0, 1);
    add(1, 8'h43, 1, 0, 8'h00, 0, 1,  0, 8'h41, 2'b01, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h41, 2'b01, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 8'h43, 2'b01, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h43, 2'b01, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h43, 2'b01, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h43, 2'b00, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h43, 2'b10, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 8'h42, 2'b10, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h42, 2'b10, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h42, 2'b10, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h42, 2'b00, 0, 0, 0);
    foreach (vq[i]) begin
      bus.a_wr = vq[i].aw; bus.a_data = vq[i].ad; bus.a_last = vq[i].al;
      bus.b_wr = vq[i].bw; bus.b_data = vq[i].bd; bus.b_last = vq[i].bl;
      vec_busy = vq[i].busy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 40'(outs()), 40'(vq[i].exp));
    end
    bus.a_wr = 1'b0; bus.b_wr = 1'b0; vec_busy = 1'b0;
    check("order_41_43_42", 40'({log_q[1], log_q[2], log_q[3]}), 40'h41_43_42);
    repeat (3) @(posedge clk);
    #1;
    use_model = 1'b1;
    log_q.delete();
    // A 4-byte frame with B pending: B must wait for A's final byte
    send(0, 8'hA1, 0);
    send(1, 8'hB1, 1);
    send(0, 8'hA2, 0);
    send(0, 8'hA3, 0);
    send(0, 8'hA4, 1);
    wait_log(5, "frame_count");
    check("frame_order", 40'({log_q[0], log_q[1], log_q[2], log_q[3], log_q[4]}), 40'hA1_A2_A3_A4_B1);
    wait_gnt0("frame_idle");
    log_q.delete();
    // idle owner forcibly released after 8 empty OWN cycles
    send(0, 8'h55, 0);
    send(1, 8'h66, 1);
    wait_tx_wr("to_issue");
    n = 0;
    for (int i = 0; i < 50 && !bus.timeout; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_latency", 40'(n), 40'd13);
    check("to_grant", 40'(bus.grant), 40'd0);
    @(posedge clk);
    #1;
    check("to_pulse_next", 40'({bus.timeout, bus.grant}), 40'b0_10);
    wait_log(2, "to_count");
    check("to_order", 40'({log_q[0], log_q[1]}), 40'h5566);
    wait_gnt0("to_idle");
    // reset during DRAIN with B holding a byte
    send(0, 8'h77, 1);
    send(1, 8'h88, 1);
    wait_tx_wr("rst_issue");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("rst_async", 40'(outs()), 40'd0);
    log_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_b_lost", 40'({8'(log_q.size()), bus.b_busy, bus.grant}), 40'd0);
`ifdef UART_TX_ARB_STATS_EN
    send(0, 8'h01, 1);
    wait_log(1, "st_b1");
    wait_gnt0("st_g1");
    send(0, 8'h02, 1);
    wait_log(2, "st_b2");
    wait_gnt0("st_g2");
    send(0, 8'h03, 0);
    wait_log(3, "st_b3");
    wait_gnt0("st_g3");
    repeat (2) @(posedge clk);
    #1;
    check("stats", 40'({bus.cnt_a, bus.cnt_b, bus.cnt_to}), 40'h0003_0000_01);
    bus.stats_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.stats_clr = 1'b0;
    check("stats_clr", 40'({bus.cnt_a, bus.cnt_b, bus.cnt_to}), 40'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
